pixel_timing_gen: RTL

PIXEL_TIMING_GEN -- requirements
Module: pixel_timing_gen

---
 rtl/pixel_timing_pkg.sv | 15 +
 rtl/pixel_timing_gen_if.sv | 36 +++
 rtl/pixel_axis_counter.sv | 28 ++
 rtl/pixel_timing_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pixel_timing_pkg.sv
// Shared definitions for the pixel timing generator.
//   state_e        : FSM states (IDLE, ACTIVE, HBLANK)
//   PT_*           : default counter width and reset-time frame geometry
package pixel_timing_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2
  } state_e;

  localparam int PT_CNT_W      = 12;
  localparam int PT_DEF_HACT   = 9;
  localparam int PT_DEF_VACT   = 9;
  localparam int PT_DEF_HBLANK = 0;
endpackage

// File: rtl/pixel_timing_gen_if.sv
// Pixel stream + configuration bundle.
//   master : upstream/config side (drives enable, cfg_*, valid_in)
//   slave  : the timing generator (drives in_ready, per-beat outputs, status)
interface pixel_timing_gen_if #(
  parameter int CNT_W = 12
) ();
  logic             enable;
  logic             cfg_load;
  logic [CNT_W-1:0] cfg_hact;
  logic [CNT_W-1:0] cfg_vact;
  logic [CNT_W-1:0] cfg_hblank;
  logic             valid_in;
  logic             in_ready;
  logic             valid;
  logic             hStart;
  logic             hEnd;
  logic             vStart;
  logic             vEnd;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             frame_done;
  logic [15:0]      frame_cnt;
  logic             cfg_err;

  modport master (
    output enable, cfg_load, cfg_hact, cfg_vact, cfg_hblank, valid_in,
    input  in_ready, valid, hStart, hEnd, vStart, vEnd, x, y,
           frame_done, frame_cnt, cfg_err
  );

  modport slave (
    input  enable, cfg_load, cfg_hact, cfg_vact, cfg_hblank, valid_in,
    output in_ready, valid, hStart, hEnd, vStart, vEnd, x, y,
           frame_done, frame_cnt, cfg_err
  );
endinterface

// File: rtl/pixel_axis_counter.sv
// One axis (column or row) position counter.
//   i_load/i_load_val : synchronous load (highest priority)
//   i_inc             : advance by one, wrapping to 0 after i_last
//   o_cnt             : current position
//   o_tc              : terminal count, o_cnt == i_last
module pixel_axis_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_inc)  r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/pixel_timing_gen.sv
// Pixel timing generator: walks (x,y) over an hact x vact frame, one step
// per accepted upstream beat, with optional blanking after each row.
//   clk, reset_n : clock, async active-low reset (release synchronised here)
//   bus (slave)  : enable/config/valid_in in; in_ready, per-beat flags,
//                  x/y, frame_done, frame_cnt, cfg_err out
module pixel_timing_gen
  import pixel_timing_pkg::*;
#(
  parameter int CNT_W      = PT_CNT_W,
  parameter int DEF_HACT   = PT_DEF_HACT,
  parameter int DEF_VACT   = PT_DEF_VACT,
  parameter int DEF_HBLANK = PT_DEF_HBLANK
) (
  input logic               clk,
  input logic               reset_n,
  pixel_timing_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] L_HACT   = CNT_W'(DEF_HACT);
  localparam logic [CNT_W-1:0] L_VACT   = CNT_W'(DEF_VACT);
  localparam logic [CNT_W-1:0] L_HBLANK = CNT_W'(DEF_HBLANK);

  // Assert asynchronously, release on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  state_e           r_state;
  logic [CNT_W-1:0] r_pend_hact, r_pend_vact, r_pend_hblank;
  logic [CNT_W-1:0] r_hact, r_vact, r_hblank, r_bcnt;
  logic [CNT_W-1:0] r_x, r_y;
  logic             r_valid, r_hs, r_he, r_vs, r_ve, r_fd, r_cfg_err;
  logic [15:0]      r_frame_cnt;

  logic [CNT_W-1:0] w_pend_hact, w_pend_vact, w_pend_hblank;
  logic [CNT_W-1:0] w_hlast, w_vlast, w_col, w_row;
  logic             w_col_tc, w_row_tc, w_in_ready, w_accept, w_final;
  logic             w_apply, w_cfg_bad, w_cfg_clr, w_clr;

  // A load in the same cycle as an apply point is visible immediately, so a
  // strobe coincident with the final beat lands on the next frame.
  assign w_pend_hact   = bus.cfg_load ? bus.cfg_hact   : r_pend_hact;
  assign w_pend_vact   = bus.cfg_load ? bus.cfg_vact   : r_pend_vact;
  assign w_pend_hblank = bus.cfg_load ? bus.cfg_hblank : r_pend_hblank;
  assign w_cfg_bad     = (w_pend_hact == '0) || (w_pend_vact == '0);
  assign w_cfg_clr     = bus.cfg_load && (bus.cfg_hact != '0) && (bus.cfg_vact != '0);

  assign w_hlast = (r_hact != '0) ? r_hact - 1'b1 : '0;
  assign w_vlast = (r_vact != '0) ? r_vact - 1'b1 : '0;

  assign w_in_ready = (r_state == ST_ACTIVE) && bus.enable;
  assign w_accept   = bus.valid_in && w_in_ready;
  assign w_final    = w_accept && w_col_tc && w_row_tc;
  assign w_apply    = ((r_state == ST_IDLE) && bus.enable && !r_cfg_err) || w_final;
  assign w_clr      = (r_state == ST_IDLE) || !bus.enable;

  pixel_axis_counter #(.W(CNT_W)) u_col (
    .clk(clk), .reset_n(w_rst_n), .i_load(w_clr), .i_load_val({CNT_W{1'b0}}),
    .i_inc(w_accept), .i_last(w_hlast), .o_cnt(w_col), .o_tc(w_col_tc)
  );

  pixel_axis_counter #(.W(CNT_W)) u_row (
    .clk(clk), .reset_n(w_rst_n), .i_load(w_clr), .i_load_val({CNT_W{1'b0}}),
    .i_inc(w_accept && w_col_tc), .i_last(w_vlast), .o_cnt(w_row), .o_tc(w_row_tc)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= ST_IDLE;
      r_pend_hact   <= L_HACT;
      r_pend_vact   <= L_VACT;
      r_pend_hblank <= L_HBLANK;
      r_hact        <= L_HACT;
      r_vact        <= L_VACT;
      r_hblank      <= L_HBLANK;
      r_bcnt        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_valid       <= 1'b0;
      r_hs          <= 1'b0;
      r_he          <= 1'b0;
      r_vs          <= 1'b0;
      r_ve          <= 1'b0;
      r_fd          <= 1'b0;
      r_frame_cnt   <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_pend_hact   <= w_pend_hact;
      r_pend_vact   <= w_pend_vact;
      r_pend_hblank <= w_pend_hblank;
      if (w_apply) begin
        r_hact   <= w_pend_hact;
        r_vact   <= w_pend_vact;
        r_hblank <= w_pend_hblank;
      end

      // Per-beat outputs: everything is zero on cycles without a beat.
      r_valid <= w_accept;
      r_x     <= w_accept ? w_col : '0;
      r_y     <= w_accept ? w_row : '0;
      r_hs    <= w_accept && (w_col == '0);
      r_he    <= w_accept && w_col_tc;
      r_vs    <= w_accept && (w_col == '0) && (w_row == '0);
      r_ve    <= w_final;
      r_fd    <= w_final;
      if (w_final) r_frame_cnt <= r_frame_cnt + 16'd1;

      if (w_apply && w_cfg_bad) r_cfg_err <= 1'b1;
      else if (w_cfg_clr)       r_cfg_err <= 1'b0;

      if (!bus.enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:
            if (!r_cfg_err && !w_cfg_bad) r_state <= ST_ACTIVE;
          ST_ACTIVE:
            if (w_accept && w_col_tc) begin
              if (w_final && w_cfg_bad) begin
                r_state <= ST_IDLE;
              end else if (r_hblank != '0) begin
                // Blanking after a row uses the geometry that row belonged to.
                r_state <= ST_HBLANK;
                r_bcnt  <= r_hblank - 1'b1;
              end
            end
          ST_HBLANK:
            if (r_bcnt == '0) r_state <= ST_ACTIVE;
            else              r_bcnt  <= r_bcnt - 1'b1;
          default:
            r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.valid      = r_valid;
  assign bus.hStart     = r_hs;
  assign bus.hEnd       = r_he;
  assign bus.vStart     = r_vs;
  assign bus.vEnd       = r_ve;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.frame_done = r_fd;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.cfg_err    = r_cfg_err;
endmodule
